// File: rtl/nonce_hub_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : nonce_hub_arbiter_if
// Description : Result-source and uplink signal bundle for nonce_hub_arbiter.
//               golden_src exists only when NONCE_HUB_TAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface nonce_hub_arbiter_if #(
    parameter int SLAVES    = 2,
    parameter int NONCE_W   = 32,
    parameter int FIFO_LOG2 = 2
);
    localparam int c_CHW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    logic [SLAVES*NONCE_W-1:0] slave_nonces;
    logic [SLAVES-1:0]         new_nonces;
    logic                      serial_busy;
    logic                      serial_send;
    logic [NONCE_W-1:0]        golden_nonce;
`ifdef NONCE_HUB_TAG_EN
    logic [c_CHW-1:0]          golden_src;
`endif
    logic [SLAVES-1:0]         pending;
    logic [FIFO_LOG2:0]        fifo_level;
    logic [SLAVES-1:0]         lost;

    // master: the hub itself (drives the uplink); slave: sources and transmitter
`ifdef NONCE_HUB_TAG_EN
    modport master (
        input  slave_nonces, new_nonces, serial_busy,
        output serial_send, golden_nonce, golden_src, pending, fifo_level, lost
    );
    modport slave (
        output slave_nonces, new_nonces, serial_busy,
        input  serial_send, golden_nonce, golden_src, pending, fifo_level, lost
    );
`else
    modport master (
        input  slave_nonces, new_nonces, serial_busy,
        output serial_send, golden_nonce, pending, fifo_level, lost
    );
    modport slave (
        output slave_nonces, new_nonces, serial_busy,
        input  serial_send, golden_nonce, pending, fifo_level, lost
    );
`endif
endinterface
`default_nettype wire

// File: rtl/nonce_hub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nonce_hub_arbiter
// Description : Merges golden nonces from SLAVES sources through round-robin
//               arbitration and a shared FIFO into one serial uplink.
//               Optional macro NONCE_HUB_TAG_EN adds source-channel tagging.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_hub_arbiter #(
    parameter int SLAVES    = 2,
    parameter int NONCE_W   = 32,
    parameter int FIFO_LOG2 = 2
) (
    input  wire logic           hash_clk,
    input  wire logic           rst_n,
    nonce_hub_arbiter_if.master bus
);
    localparam int c_CHW   = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int c_DEPTH = 1 << FIFO_LOG2;
`ifdef NONCE_HUB_TAG_EN
    localparam int c_ENTRY_W = NONCE_W + c_CHW;
`else
    localparam int c_ENTRY_W = NONCE_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // capture stage
    logic [NONCE_W-1:0]   r_hold [SLAVES];
    logic [SLAVES-1:0]    r_pend;
    logic [SLAVES-1:0]    r_lost;

    // arbiter
    logic [c_CHW-1:0]     r_rr_ptr;
    logic [c_CHW-1:0]     w_cand;
    logic [c_CHW-1:0]     w_grant_idx;
    logic [SLAVES-1:0]    w_grant;
    logic                 w_found;
    logic                 w_arb_en;

    // FIFO
    logic [c_ENTRY_W-1:0] r_mem [c_DEPTH];
    logic [FIFO_LOG2-1:0] r_wr_ptr;
    logic [FIFO_LOG2-1:0] r_rd_ptr;
    logic [FIFO_LOG2:0]   r_level;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // transmit FSM
    state_t               r_state;
    logic                 r_wait_cnt;
    logic                 r_send;
    logic [NONCE_W-1:0]   r_golden;
`ifdef NONCE_HUB_TAG_EN
    logic [c_CHW-1:0]     r_src;
`endif

    assign w_full   = (r_level == (FIFO_LOG2+1)'(c_DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_arb_en = (|r_pend) && !w_full;

    // Rotating search starting just after the last granted channel
    always_comb begin
        w_cand      = '0;
        w_grant_idx = '0;
        w_grant     = '0;
        w_found     = 1'b0;
        if (w_arb_en) begin
            for (int k = 1; k <= SLAVES; k++) begin
                w_cand = c_CHW'((int'(r_rr_ptr) + k) % SLAVES);
                if (!w_found && r_pend[w_cand]) begin
                    w_found            = 1'b1;
                    w_grant_idx        = w_cand;
                    w_grant            = '0;
                    w_grant[w_cand]    = 1'b1;
                end
            end
        end
    end

    assign w_push = w_found;
`ifdef NONCE_HUB_TAG_EN
    assign w_push_data = {w_grant_idx, r_hold[w_grant_idx]};
`else
    assign w_push_data = r_hold[w_grant_idx];
`endif

    // A strobe on the grant cycle re-arms pend; the granted old value is already in flight
    always_ff @(posedge hash_clk) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_lost <= '0;
            for (int i = 0; i < SLAVES; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLAVES; i++) begin
                if (bus.new_nonces[i]) begin
                    r_hold[i] <= bus.slave_nonces[i*NONCE_W +: NONCE_W];
                    r_pend[i] <= 1'b1;
                    if (r_pend[i] && !w_grant[i]) begin
                        r_lost[i] <= 1'b1;
                    end
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge hash_clk) begin
        if (!rst_n) begin
            r_rr_ptr <= c_CHW'(SLAVES - 1);
        end else if (w_found) begin
            r_rr_ptr <= w_grant_idx;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign w_head = r_mem[r_rd_ptr];
    assign w_pop  = (r_state == S_IDLE) && !w_empty && !bus.serial_busy;

    always_ff @(posedge hash_clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Restart in IDLE gates on serial_busy, so a frame in flight across reset is never clobbered
    always_ff @(posedge hash_clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 1'b0;
            r_send     <= 1'b0;
            r_golden   <= '0;
`ifdef NONCE_HUB_TAG_EN
            r_src      <= '0;
`endif
        end else begin
            r_send <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_golden <= w_head[NONCE_W-1:0];
`ifdef NONCE_HUB_TAG_EN
                        r_src    <= w_head[c_ENTRY_W-1 -: c_CHW];
`endif
                        r_send   <= 1'b1;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_wait_cnt <= 1'b0;
                    r_state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (bus.serial_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_wait_cnt) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.serial_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.serial_send  = r_send;
    assign bus.golden_nonce = r_golden;
`ifdef NONCE_HUB_TAG_EN
    assign bus.golden_src   = r_src;
`endif
    assign bus.pending      = r_pend;
    assign bus.fifo_level   = r_level;
    assign bus.lost         = r_lost;

endmodule
`default_nettype wire
